// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, response error codes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_OOR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store-data replication,
// load extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlanes,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_be     = '0;
    o_wlanes = '0;
    o_rdata  = '0;
    case (i_size)
      SZ_B: begin
        o_be     = 4'b0001 << i_addr_lo;
        o_wlanes = {4{i_wdata[7:0]}};
        o_rdata  = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_H: begin
        o_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wlanes = {2{i_wdata[15:0]}};
        o_rdata  = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      SZ_W: begin
        o_be     = 4'b1111;
        o_wlanes = i_wdata;
        o_rdata  = w_shifted;
      end
      default: ;
    endcase
  end

  assign o_misaligned = (i_size == SZ_H && i_addr_lo[0]) ||
                        (i_size == SZ_W && i_addr_lo != 2'b00) ||
                        (i_size == SZ_X);

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data RAM with valid/ready request and registered one-cycle response.
// Optional DMEM_CLEAR_EN: reset zeroes the array one word per cycle before accepting requests.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_err_o
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);

  logic [7:0]  r_mem [DEPTH_WORDS*4];
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  dmem_req_t   r_req;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic [1:0]  r_rsp_err;

  dmem_req_t        w_live;
  dmem_req_t        w_cur;
  logic             w_accept;
  logic             w_access;
  logic             w_mem_we;
  logic [31:0]      w_off;
  logic             w_oor;
  logic [IDX_W-1:0] w_widx;
  logic [31:0]      w_rword;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes;
  logic [31:0]      w_load;
  logic             w_mis;
  logic [1:0]       w_err;

  assign req_ready_o = (r_state == ST_IDLE) && !reset;
  assign w_accept    = req_valid_i && req_ready_o;

  assign w_live = '{we: req_we_i, size: req_size_i, uns: req_unsigned_i,
                    addr: req_addr_i, wdata: req_wdata_i};
  // With LATENCY=1 the access happens on the accept edge, so it must use the live request fields.
  assign w_cur  = w_accept ? w_live : r_req;

  // r_cnt counts the edges still to go; the access is performed on the edge where it reaches zero.
  assign w_access = (w_accept && LATENCY == 1) || (r_state == ST_BUSY && r_cnt == 4'd1);

  assign w_off   = w_cur.addr - BASE_ADDR;
  assign w_oor   = (w_off >= DEPTH_BYTES);
  assign w_widx  = w_off[IDX_W+1:2];
  assign w_rword = {r_mem[{w_widx, 2'd3}], r_mem[{w_widx, 2'd2}],
                    r_mem[{w_widx, 2'd1}], r_mem[{w_widx, 2'd0}]};

  dmem_lane_align u_lane_align (
    .i_addr_lo    (w_cur.addr[1:0]),
    .i_size       (w_cur.size),
    .i_unsigned   (w_cur.uns),
    .i_wdata      (w_cur.wdata),
    .i_rword      (w_rword),
    .o_be         (w_be),
    .o_wlanes     (w_wlanes),
    .o_rdata      (w_load),
    .o_misaligned (w_mis)
  );

  assign w_err    = w_mis ? ERR_MIS : (w_oor ? ERR_OOR : ERR_OK);
  assign w_mem_we = w_access && !reset && w_cur.we && (w_err == ERR_OK);

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] r_clr_idx;
  logic             w_clr_we;
  assign w_clr_we = (r_state == ST_CLEAR) && !reset;
`endif

  // NOTE: the storage array has no reset; clearing it is an explicit FSM activity, not a flop reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[{w_widx, 2'(k)}] <= w_wlanes[8*k +: 8];
      end
    end
`ifdef DMEM_CLEAR_EN
    if (w_clr_we) begin
      for (int k = 0; k < 4; k++) r_mem[{r_clr_idx, 2'(k)}] <= 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_CLEAR_EN
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
`else
      r_state   <= ST_IDLE;
`endif
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req   <= w_live;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
`ifdef DMEM_CLEAR_EN
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err == ERR_OK && !w_cur.we) ? w_load : 32'h0;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule
